pixel_seq_ctrl: RTL and testbench

//  Frame sequencer for pixelTop: drives erase -> expose -> convert -> banked readout (read per bank).

---
 rtl/pixel_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pixel_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_seq_ctrl
// Frame sequencer for the pixel array: erase -> expose -> convert -> banked
// readout, one read line per bank, with downstream back-pressure on readout
// and a one-cycle frame_done pulse after the last beat of the last bank.
//
// Ports
//   clk         in   1        system clock, all logic on posedge
//   reset       in   1        synchronous, active-high
//   start       in   1        request one frame; honoured only while idle
//   continuous  in   1        sampled on the last read beat: 1 = restart, 0 = idle
//   rd_ready    in   1        downstream accepts the current read beat
//   erase       out  1        pixel erase
//   expose      out  1        pixel expose
//   convert     out  1        ADC ramp enable
//   read        out  N_BANKS  one-hot bank select
//   busy        out  1        high whenever a frame is in progress
//   frame_done  out  1        one-cycle pulse after the final read beat
// -----------------------------------------------------------------------------
module pixel_seq_ctrl #(
    parameter int N_BANKS   = 4,
    parameter int C_ERASE   = 5,
    parameter int C_EXPOSE  = 255,
    parameter int C_CONVERT = 255,
    parameter int C_READ    = 1,
    parameter int CW        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    input  logic               rd_ready,
    output logic               erase,
    output logic               expose,
    output logic               convert,
    output logic [N_BANKS-1:0] read,
    output logic               busy,
    output logic               frame_done
);

    localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

    localparam logic [CW-1:0] ERASE_LAST   = CW'(C_ERASE - 1);
    localparam logic [CW-1:0] EXPOSE_LAST  = CW'(C_EXPOSE - 1);
    localparam logic [CW-1:0] CONVERT_LAST = CW'(C_CONVERT - 1);
    localparam logic [CW-1:0] READ_LAST    = CW'(C_READ - 1);
    localparam logic [BW-1:0] BANK_LAST    = BW'(N_BANKS - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [BW-1:0] BANK_ONE     = BW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [BW-1:0]      bank_r, bank_s;
    // start is captured for one cycle before the frame begins, so the first
    // erase cycle lands one edge after the edge that sampled start.
    logic               start_q_r, start_q_s;
    logic               erase_r, erase_s;
    logic               expose_r, expose_s;
    logic               convert_r, convert_s;
    logic [N_BANKS-1:0] read_r, read_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    // Next-state, counter/bank update and registered-output decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bank_s    = bank_r;
        start_q_s = 1'b0;
        done_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_s  = {CW{1'b0}};
                bank_s = {BW{1'b0}};
                if (start_q_r) begin
                    state_s = ST_ERASE;
                end else begin
                    start_q_s = start;
                end
            end
            ST_ERASE: begin
                if (cnt_r == ERASE_LAST) begin
                    state_s = ST_EXPOSE;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_EXPOSE: begin
                if (cnt_r == EXPOSE_LAST) begin
                    state_s = ST_CONVERT;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_CONVERT: begin
                if (cnt_r == CONVERT_LAST) begin
                    state_s = ST_READ;
                    cnt_s   = {CW{1'b0}};
                    bank_s  = {BW{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_READ: begin
                // A beat is accepted only while the bank's read line is driven.
                if (read_r[bank_r] && rd_ready) begin
                    if (cnt_r == READ_LAST) begin
                        cnt_s = {CW{1'b0}};
                        if (bank_r == BANK_LAST) begin
                            bank_s  = {BW{1'b0}};
                            done_s  = 1'b1;
                            state_s = continuous ? ST_ERASE : ST_IDLE;
                        end else begin
                            bank_s = bank_r + BANK_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
                bank_s  = {BW{1'b0}};
            end
        endcase

        // Outputs are decoded from the next state so they register together
        // with the state they describe.
        erase_s   = (state_s == ST_ERASE);
        expose_s  = (state_s == ST_EXPOSE);
        convert_s = (state_s == ST_CONVERT);
        busy_s    = (state_s != ST_IDLE);
        read_s    = {N_BANKS{1'b0}};
        if (state_s == ST_READ) begin
            read_s[bank_s] = 1'b1;
        end else begin
            read_s = {N_BANKS{1'b0}};
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            bank_r    <= {BW{1'b0}};
            start_q_r <= 1'b0;
            erase_r   <= 1'b0;
            expose_r  <= 1'b0;
            convert_r <= 1'b0;
            read_r    <= {N_BANKS{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bank_r    <= bank_s;
            start_q_r <= start_q_s;
            erase_r   <= erase_s;
            expose_r  <= expose_s;
            convert_r <= convert_s;
            read_r    <= read_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign erase      = erase_r;
    assign expose     = expose_r;
    assign convert    = convert_r;
    assign read       = read_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pixel_seq_ctrl
// Self-checking bench for pixel_seq_ctrl. A small-parameter instance is
// compared every cycle against a frame-schedule model (elapsed cycles and
// accepted beats); a default-parameter instance checks long-frame timing.
// -----------------------------------------------------------------------------
module tb_pixel_seq_ctrl;

    localparam int CE  = 2;
    localparam int CX  = 3;
    localparam int CC  = 4;
    localparam int CR  = 2;
    localparam int NB  = 4;
    localparam int FIX = CE + CX + CC;
    localparam int TOTAL_BEATS = NB * CR;

    logic          clk;
    logic          reset;
    logic          start;
    logic          continuous;
    logic          rd_ready;
    logic          erase, expose, convert, busy, frame_done;
    logic [NB-1:0] read;

    logic          start2;
    logic          erase2, expose2, convert2, busy2, frame_done2;
    logic [3:0]    read2;

    int checks;
    int errors;

    pixel_seq_ctrl #(
        .N_BANKS(NB), .C_ERASE(CE), .C_EXPOSE(CX), .C_CONVERT(CC), .C_READ(CR), .CW(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .rd_ready(rd_ready), .erase(erase), .expose(expose), .convert(convert),
        .read(read), .busy(busy), .frame_done(frame_done)
    );

    pixel_seq_ctrl dut2 (
        .clk(clk), .reset(reset), .start(start2), .continuous(1'b0),
        .rd_ready(1'b1), .erase(erase2), .expose(expose2), .convert(convert2),
        .read(read2), .busy(busy2), .frame_done(frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   m_mode;   // 0 idle, 1 start seen, 2 frame running
    int   m_t;      // cycles elapsed in the fixed-length part of the frame
    int   m_beats;  // accepted read beats in this frame
    logic m_done;

    function automatic logic [8:0] m_vec();
        logic e, x, c, b;
        logic [NB-1:0] r;
        e = 1'b0; x = 1'b0; c = 1'b0; b = 1'b0; r = '0;
        if (m_mode == 2) begin
            b = 1'b1;
            if (m_t < CE) e = 1'b1;
            else if (m_t < CE + CX) x = 1'b1;
            else if (m_t < FIX) c = 1'b1;
            else r[m_beats / CR] = 1'b1;
        end
        return {e, x, c, r, b, m_done};
    endfunction

    task automatic model_step(input logic st, input logic cont, input logic rdy, input logic rst);
        if (rst) begin
            m_mode = 0; m_t = 0; m_beats = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_mode == 0) begin
                if (st) m_mode = 1;
            end else if (m_mode == 1) begin
                m_mode = 2; m_t = 0; m_beats = 0;
            end else if (m_t < FIX) begin
                m_t++;
            end else if (rdy) begin
                m_beats++;
                if (m_beats == TOTAL_BEATS) begin
                    m_done = 1'b1; m_t = 0; m_beats = 0;
                    if (!cont) m_mode = 0;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int   cyc;
    int   done_first, done_last, done_cnt, beats_obs;
    logic [1:0] snap18;
    logic [8:0] snap8;

    task automatic clear_stats();
        cyc = -1; done_first = -1; done_last = -1; done_cnt = 0; beats_obs = 0;
        snap18 = 2'b00; snap8 = 9'h1FF;
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic tick(input logic st, input logic cont, input logic rdy, input logic rst);
        start = st; continuous = cont; rd_ready = rdy; reset = rst;
        if (read != '0 && rdy && !rst) beats_obs++;
        @(posedge clk);
        model_step(st, cont, rdy, rst);
        #1;
        cyc++;
        if (frame_done) begin
            if (done_first < 0) done_first = cyc;
            done_last = cyc;
            done_cnt++;
        end
        if (cyc == 18) snap18 = {erase, frame_done};
        if (cyc == 8) snap8 = {erase, expose, convert, read, busy, frame_done};
        chk("cycle_outputs", 32'({erase, expose, convert, read, busy, frame_done}), 32'(m_vec()));
    endtask

    int conv_cnt, busy_cnt, done2_cnt, cnt_max;

    initial begin
        checks = 0; errors = 0;
        start = 1'b0; continuous = 1'b0; rd_ready = 1'b1; reset = 1'b1; start2 = 1'b0;
        m_mode = 0; m_t = 0; m_beats = 0; m_done = 1'b0;
        clear_stats();

        // Reset
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        chk("reset_dut2", 32'({erase2, expose2, convert2, read2, busy2, frame_done2}), 32'd0);

        // Test 1: single frame, no back-pressure
        clear_stats();
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (22) tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_done_cycle", 32'(done_first), 32'd18);
        chk("t1_done_count", 32'(done_cnt), 32'd1);
        chk("t1_read_beats", 32'(beats_obs), 32'(TOTAL_BEATS));

        // Test 2: stall for cycles 12..16
        clear_stats();
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (27) tick(1'b0, 1'b0, !(cyc >= 12 && cyc <= 16), 1'b0);
        chk("t2_done_cycle", 32'(done_first), 32'd23);
        chk("t2_read_beats", 32'(beats_obs), 32'(TOTAL_BEATS));

        // Test 3: continuous, dropped during the second frame
        clear_stats();
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (40) tick(1'b0, (cyc < 20), 1'b1, 1'b0);
        chk("t3_done_and_erase_c18", 32'(snap18), 32'd3);
        chk("t3_first_done", 32'(done_first), 32'd18);
        chk("t3_second_done", 32'(done_last), 32'd35);
        chk("t3_done_count", 32'(done_cnt), 32'd2);

        // Test 4: reset during convert, then a clean frame
        clear_stats();
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (14) tick(1'b0, 1'b0, 1'b1, (cyc == 7));
        chk("t4_outputs_c8", 32'(snap8), 32'd0);
        chk("t4_no_done", 32'(done_cnt), 32'd0);
        clear_stats();
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (22) tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_refill_done_cycle", 32'(done_first), 32'd18);

        // Test 5: start pulses inside a running frame are ignored
        clear_stats();
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (32) tick((cyc == 4 || cyc == 15), 1'b0, 1'b1, 1'b0);
        chk("t5_done_count", 32'(done_cnt), 32'd1);
        chk("t5_idle_after", 32'(busy), 32'd0);

        // Randomized traffic against the model
        clear_stats();
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end
        tick(1'b0, 1'b0, 1'b1, 1'b1);

        // Test 6: default parameters, long frame
        reset = 1'b0; start = 1'b0;
        conv_cnt = 0; busy_cnt = 0; done2_cnt = 0; cnt_max = 0;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (convert2) conv_cnt++;
            if (busy2) busy_cnt++;
            if (frame_done2) done2_cnt++;
            if (int'(dut2.cnt_r) > cnt_max) cnt_max = int'(dut2.cnt_r);
            @(posedge clk); #1;
        end
        chk("t6_convert_cycles", 32'(conv_cnt), 32'd255);
        chk("t6_frame_length", 32'(busy_cnt), 32'd519);
        chk("t6_done_count", 32'(done2_cnt), 32'd1);
        chk("t6_counter_max_ok", 32'(cnt_max <= 254), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
